// File: rtl/pump_pkg.sv
// Shared encodings for the front-panel command generator
// and the pump controller it feeds.
package pump_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [1:0] CMD_TURN_OFF   = 2'b00;
  localparam logic [1:0] CMD_TURN_ON    = 2'b01;
  localparam logic [1:0] CMD_STOP_PUMP  = 2'b10;
  localparam logic [1:0] CMD_START_PUMP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP
  } gen_state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_POWER,
    EV_PUMP
  } btn_event_e;

endpackage

// File: rtl/pump_cmd_gen_debounce.sv
// Button conditioner: 2-FF synchronizer, consecutive-sample
// debouncer and a 1-cycle pulse on each debounced press.
module btn_debounce
  import pump_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= LOW;
      sync2_q <= LOW;
      level_q <= LOW;
      press_q <= LOW;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= LOW;
      if (sync2_q != level_q) begin
        if (cnt_q == LAST) begin
          level_q <= ~level_q;
          press_q <= ~level_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pump_cmd_gen.sv
// Front-panel command generator: turns debounced presses into
// pump commands delivered with a setup/strobe/gap handshake.
module pump_cmd_gen
  import pump_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STROBE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_power,
  input  logic       btn_pump,
  output logic [1:0] command,
  output logic       update,
  output logic       busy
);

  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam logic [SW-1:0] SLAST = SW'(STROBE_CYCLES - 1);

  logic pwr_press;
  logic pmp_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pwr (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_power),
    .press_o (pwr_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pmp (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_pump),
    .press_o (pmp_press)
  );

  gen_state_e    state_q;
  btn_event_e    slot_q;
  btn_event_e    slot_d;
  logic [1:0]    cmd_q;
  logic [1:0]    cmd_d;
  logic          upd_q;
  logic          busy_q;
  logic          pwr_on_q;
  logic          pwr_on_d;
  logic          pmp_on_q;
  logic          pmp_on_d;
  logic [SW-1:0] scnt_q;

  btn_event_e live;
  btn_event_e ev;
  btn_event_e base;
  logic       idle;
  logic       take_slot;
  logic       issue;

  always_comb begin
    live      = pwr_press ? EV_POWER :
                pmp_press ? EV_PUMP : EV_NONE;
    idle      = (state_q == ST_IDLE);
    take_slot = idle && (slot_q != EV_NONE);
    ev        = take_slot ? slot_q :
                idle      ? live   : EV_NONE;
    base      = take_slot ? EV_NONE : slot_q;

    // A live press not handled directly this cycle competes for the slot.
    slot_d = base;
    if (!idle || take_slot) begin
      if (live == EV_POWER)
        slot_d = EV_POWER;
      else if (live == EV_PUMP && base == EV_NONE)
        slot_d = EV_PUMP;
    end

    issue    = LOW;
    cmd_d    = cmd_q;
    pwr_on_d = pwr_on_q;
    pmp_on_d = pmp_on_q;
    unique case (1'b1)
      (ev == EV_POWER): begin
        issue = HIGH;
        if (pwr_on_q) begin
          cmd_d    = CMD_TURN_OFF;
          pwr_on_d = LOW;
          pmp_on_d = LOW;
        end else begin
          cmd_d    = CMD_TURN_ON;
          pwr_on_d = HIGH;
        end
      end
      (ev == EV_PUMP): begin
        if (pwr_on_q) begin
          issue    = HIGH;
          cmd_d    = pmp_on_q ? CMD_STOP_PUMP : CMD_START_PUMP;
          pmp_on_d = ~pmp_on_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      slot_q   <= EV_NONE;
      cmd_q    <= CMD_TURN_OFF;
      upd_q    <= LOW;
      busy_q   <= LOW;
      pwr_on_q <= LOW;
      pmp_on_q <= LOW;
      scnt_q   <= '0;
    end else begin
      slot_q <= slot_d;
      unique case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q  <= ST_SETUP;
            cmd_q    <= cmd_d;
            pwr_on_q <= pwr_on_d;
            pmp_on_q <= pmp_on_d;
            busy_q   <= HIGH;
          end
        end
        ST_SETUP: begin
          state_q <= ST_STROBE;
          upd_q   <= HIGH;
          scnt_q  <= SLAST;
        end
        ST_STROBE: begin
          if (scnt_q == '0) begin
            state_q <= ST_GAP;
            upd_q   <= LOW;
          end else begin
            scnt_q <= scnt_q - SW'(1);
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
          busy_q  <= LOW;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign command = cmd_q;
  assign update  = upd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pump_cmd_gen.sv
// Directed bench for pump_cmd_gen: timing, bounce, model,
// pending slot and reset behaviour.
module tb_pump_cmd_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_power = 1'b0;
  logic       btn_pump = 1'b0;
  logic [1:0] cmd;
  logic       upd;
  logic       bsy;
  logic [1:0] cmd_l;
  logic       upd_l;
  logic       bsy_l;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] rises[$];
  logic [1:0] rises_l[$];
  logic       pu = 1'b0;
  logic       pul = 1'b0;
  bit         busy_seen = 1'b0;

  pump_cmd_gen dut (
    .clk       (clk),
    .reset     (reset),
    .btn_power (btn_power),
    .btn_pump  (btn_pump),
    .command   (cmd),
    .update    (upd),
    .busy      (bsy)
  );

  // Long strobe gives room for presses to land while busy.
  pump_cmd_gen #(.DEBOUNCE_CYCLES(4), .STROBE_CYCLES(20)) dut_l (
    .clk       (clk),
    .reset     (reset),
    .btn_power (btn_power),
    .btn_pump  (btn_pump),
    .command   (cmd_l),
    .update    (upd_l),
    .busy      (bsy_l)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd && !pu) rises.push_back(cmd);
    if (upd_l && !pul) rises_l.push_back(cmd_l);
    pu = upd;
    pul = upd_l;
    if (bsy) busy_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_power = 1'b0;
    btn_pump = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    rises.delete();
    rises_l.delete();
  endtask

  task automatic press(input bit pwr, input bit pmp, input int hold);
    btn_power = pwr;
    btn_pump = pmp;
    tick(hold);
    btn_power = 1'b0;
    btn_pump = 1'b0;
    tick(14);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    vectors++;
    if (cmd !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_cmd got=%b exp=00", cmd);
    end
    vectors++;
    if (upd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_upd got=%b exp=0", upd);
    end
    vectors++;
    if (bsy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got=%b exp=0", bsy);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_power_on();
    do_reset();
    btn_power = 1'b1;
    tick(1);
    tick(5);
    vectors++;
    if (cmd !== 2'b00 || bsy !== 1'b0) begin
      miscompares++;
      $display("FAIL pon_e5 got=%b/%b exp=00/0", cmd, bsy);
    end
    tick(1);
    vectors++;
    if (cmd !== 2'b01 || bsy !== 1'b1 || upd !== 1'b0) begin
      miscompares++;
      $display("FAIL pon_e6 got=%b/%b/%b exp=01/1/0", cmd, bsy, upd);
    end
    tick(1);
    vectors++;
    if (upd !== 1'b1) begin
      miscompares++;
      $display("FAIL pon_e7 upd got=%b exp=1", upd);
    end
    tick(1);
    vectors++;
    if (upd !== 1'b1) begin
      miscompares++;
      $display("FAIL pon_e8 upd got=%b exp=1", upd);
    end
    tick(1);
    vectors++;
    if (upd !== 1'b0 || bsy !== 1'b1) begin
      miscompares++;
      $display("FAIL pon_e9 got=%b/%b exp=0/1", upd, bsy);
    end
    tick(1);
    vectors++;
    if (bsy !== 1'b0 || cmd !== 2'b01) begin
      miscompares++;
      $display("FAIL pon_e10 got=%b/%b exp=0/01", bsy, cmd);
    end
    btn_power = 1'b0;
    tick(14);
    vectors++;
    if (rises.size() != 1) begin
      miscompares++;
      $display("FAIL pon_count got=%0d exp=1", rises.size());
    end
  endtask

  task automatic test_bounce();
    logic [1:0] got;
    rises.delete();
    for (int i = 0; i < 5; i++) begin
      btn_pump = 1'b1;
      tick(1);
      btn_pump = 1'b0;
      tick(1);
    end
    tick(12);
    vectors++;
    if (rises.size() != 0) begin
      miscompares++;
      $display("FAIL bounce_none got=%0d exp=0", rises.size());
    end
    press(1'b0, 1'b1, 10);
    got = (rises.size() > 0) ? rises[0] : 2'bxx;
    vectors++;
    if (rises.size() != 1 || got !== 2'b11) begin
      miscompares++;
      $display("FAIL bounce_start got=%0d/%b exp=1/11", rises.size(), got);
    end
    press(1'b0, 1'b1, 10);
    got = (rises.size() > 1) ? rises[1] : 2'bxx;
    vectors++;
    if (rises.size() != 2 || got !== 2'b10) begin
      miscompares++;
      $display("FAIL bounce_stop got=%0d/%b exp=2/10", rises.size(), got);
    end
  endtask

  task automatic test_pump_off();
    logic [1:0] got;
    do_reset();
    busy_seen = 1'b0;
    press(1'b0, 1'b1, 10);
    vectors++;
    if (rises.size() != 0 || busy_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL off_pump got=%0d/%b exp=0/0", rises.size(), busy_seen);
    end
    press(1'b1, 1'b0, 10);
    got = (rises.size() > 0) ? rises[0] : 2'bxx;
    vectors++;
    if (rises.size() != 1 || got !== 2'b01) begin
      miscompares++;
      $display("FAIL off_pon got=%0d/%b exp=1/01", rises.size(), got);
    end
    press(1'b1, 1'b0, 10);
    got = (rises.size() > 1) ? rises[1] : 2'bxx;
    vectors++;
    if (rises.size() != 2 || got !== 2'b00) begin
      miscompares++;
      $display("FAIL off_poff got=%0d/%b exp=2/00", rises.size(), got);
    end
    press(1'b0, 1'b1, 10);
    vectors++;
    if (rises.size() != 2 || cmd !== 2'b00) begin
      miscompares++;
      $display("FAIL off_pump2 got=%0d/%b exp=2/00", rises.size(), cmd);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] got;
    do_reset();
    press(1'b1, 1'b1, 10);
    tick(10);
    got = (rises.size() > 0) ? rises[0] : 2'bxx;
    vectors++;
    if (rises.size() != 1 || got !== 2'b01 || cmd !== 2'b01) begin
      miscompares++;
      $display("FAIL simul got=%0d/%b/%b exp=1/01/01",
               rises.size(), got, cmd);
    end
  endtask

  task automatic test_pending();
    logic [1:0] got;
    do_reset();
    btn_power = 1'b1;
    tick(1);
    tick(7);
    vectors++;
    if (upd_l !== 1'b1 || cmd_l !== 2'b01) begin
      miscompares++;
      $display("FAIL pend_strobe got=%b/%b exp=1/01", upd_l, cmd_l);
    end
    btn_pump = 1'b1;
    btn_power = 1'b0;
    tick(7);
    btn_power = 1'b1;
    tick(20);
    got = (rises_l.size() > 1) ? rises_l[1] : 2'bxx;
    vectors++;
    if (rises_l.size() != 2 || got !== 2'b00 || cmd_l !== 2'b00) begin
      miscompares++;
      $display("FAIL pend_off got=%0d/%b/%b exp=2/00/00",
               rises_l.size(), got, cmd_l);
    end
    btn_power = 1'b0;
    btn_pump = 1'b0;
    tick(40);
    vectors++;
    if (rises_l.size() != 2 || bsy_l !== 1'b0) begin
      miscompares++;
      $display("FAIL pend_single got=%0d/%b exp=2/0", rises_l.size(), bsy_l);
    end
    press(1'b0, 1'b1, 10);
    tick(30);
    vectors++;
    if (rises_l.size() != 2) begin
      miscompares++;
      $display("FAIL pend_pump got=%0d exp=2", rises_l.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] got;
    do_reset();
    btn_power = 1'b1;
    tick(1);
    tick(7);
    vectors++;
    if (upd !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_strobe got=%b exp=1", upd);
    end
    reset = 1'b1;
    btn_power = 1'b0;
    tick(1);
    vectors++;
    if (upd !== 1'b0 || cmd !== 2'b00 || bsy !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_clear got=%b/%b/%b exp=0/00/0", upd, cmd, bsy);
    end
    reset = 1'b0;
    tick(12);
    rises.delete();
    press(1'b1, 1'b0, 10);
    got = (rises.size() > 0) ? rises[0] : 2'bxx;
    vectors++;
    if (rises.size() != 1 || got !== 2'b01) begin
      miscompares++;
      $display("FAIL rmid_pon got=%0d/%b exp=1/01", rises.size(), got);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_bounce();
    test_pump_off();
    test_simultaneous();
    test_pending();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
